// File: rtl/ex_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ex_pkg
// Purpose  : Shared types and constants for the ex_stage_mc execute stage:
//            ALU opcode encodings, FSM state type, forward-select codes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // True for opcodes handled by the iterative MUL/DIV unit
    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_iter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ex_muldiv_iter
// Purpose  : Iterative unsigned multiplier (shift-add, low WIDTH bits) and
//            restoring divider. One iteration per cycle, WIDTH iterations.
//            o_done/o_result are combinational during the final iteration so
//            the caller can register the answer on that same edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    // MUL: r_x = accumulator, r_y = shifted multiplicand, r_z = multiplier
    // DIV: r_x = partial remainder, r_y = dividend/quotient, r_z = divisor
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_mul;
    logic             r_is_rem;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;

    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // One shift-add step and one restoring-division step
    always_comb begin
        w_acc_next  = r_x + (r_z[0] ? r_y : '0);
        w_rem_shift = {r_x, r_y[WIDTH-1]};
        w_diff      = w_rem_shift - {1'b0, r_z};
        w_fits      = ~w_diff[WIDTH];
        w_rem_next  = w_fits ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
        w_quo_next  = {r_y[WIDTH-2:0], w_fits};
    end

    assign o_done   = r_busy && (r_cnt == C_LAST);
    assign o_result = r_is_mul ? w_acc_next : (r_is_rem ? w_rem_next : w_quo_next);

    // Iteration state: load on start, step while busy, drop on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_is_rem <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_mul <= (i_op == OP_MUL);
            r_is_rem <= (i_op == OP_REMU);
            r_x      <= '0;
            r_y      <= i_a;
            r_z      <= i_b;
        end else if (r_busy) begin
            r_cnt <= o_done ? '0 : r_cnt + CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
            if (r_is_mul) begin
                r_x <= w_acc_next;
                r_y <= {r_y[WIDTH-2:0], 1'b0};
                r_z <= {1'b0, r_z[WIDTH-1:1]};
            end else begin
                r_x <= w_rem_next;
                r_y <= w_quo_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage_mc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ex_stage_mc
// Purpose  : MIPS execute stage: MEM/WB operand forwarding, single-cycle ALU,
//            iterative MUL/DIVU/REMU with upstream stall, EX/MEM register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  flush,
    input  logic [3:0]            alu_op,
    input  logic                  alu_src,
    input  logic                  reg_dst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [WIDTH-1:0]      rs_data,
    input  logic [WIDTH-1:0]      rt_data,
    input  logic [WIDTH-1:0]      imm,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [WIDTH-1:0]      mem_fwd_data,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [WIDTH-1:0]      wb_fwd_data,
    output logic                  stall,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_res,
    output logic [WIDTH-1:0]      out_store,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_reg_write,
    output logic                  out_mem_to_reg
);

    localparam int CNT_W = $clog2(WIDTH);

    ex_state_e             r_state;
    logic [REG_ADDR_W-1:0] r_hold_dest;
    logic [WIDTH-1:0]      r_hold_store;
    logic                  r_hold_mr;
    logic                  r_hold_mw;
    logic                  r_hold_rw;
    logic                  r_hold_m2r;

    logic [1:0]            w_sel_a;
    logic [1:0]            w_sel_b;
    logic [WIDTH-1:0]      w_fwd_a;
    logic [WIDTH-1:0]      w_fwd_b;
    logic [WIDTH-1:0]      w_b;
    logic [CNT_W-1:0]      w_shamt;
    logic [WIDTH-1:0]      w_alu;
    logic [REG_ADDR_W-1:0] w_dest;
    logic                  w_is_multi;
    logic                  w_accept;
    logic                  w_md_done;
    logic [WIDTH-1:0]      w_md_result;

    // Forward-source selection; MEM wins over WB, r0 is never forwarded
    always_comb begin
        w_sel_a = FWD_RF;
        if (mem_reg_write && (mem_dest != '0) && (mem_dest == rs)) begin
            w_sel_a = FWD_MEM;
        end else if (wb_reg_write && (wb_dest != '0) && (wb_dest == rs)) begin
            w_sel_a = FWD_WB;
        end
        w_sel_b = FWD_RF;
        if (mem_reg_write && (mem_dest != '0) && (mem_dest == rt)) begin
            w_sel_b = FWD_MEM;
        end else if (wb_reg_write && (wb_dest != '0) && (wb_dest == rt)) begin
            w_sel_b = FWD_WB;
        end
    end

    // Forwarding data muxes
    always_comb begin
        case (w_sel_a)
            FWD_MEM: w_fwd_a = mem_fwd_data;
            FWD_WB:  w_fwd_a = wb_fwd_data;
            default: w_fwd_a = rs_data;
        endcase
        case (w_sel_b)
            FWD_MEM: w_fwd_b = mem_fwd_data;
            FWD_WB:  w_fwd_b = wb_fwd_data;
            default: w_fwd_b = rt_data;
        endcase
    end

    assign w_b        = alu_src ? imm : w_fwd_b;
    assign w_shamt    = imm[CNT_W-1:0];
    assign w_dest     = reg_dst ? rd : rt;
    assign w_is_multi = is_multi(alu_op);
    assign w_accept   = ~flush && (r_state == ST_IDLE) && in_valid && w_is_multi;

    // Single-cycle ALU; multi-cycle and unused codes give 0 here
    always_comb begin
        w_alu = '0;
        case (alu_op)
            OP_ADD:  w_alu = w_fwd_a + w_b;
            OP_SUB:  w_alu = w_fwd_a - w_b;
            OP_AND:  w_alu = w_fwd_a & w_b;
            OP_OR:   w_alu = w_fwd_a | w_b;
            OP_XOR:  w_alu = w_fwd_a ^ w_b;
            OP_NOR:  w_alu = ~(w_fwd_a | w_b);
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_b))};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (w_fwd_a < w_b)};
            OP_SLL:  w_alu = w_fwd_b << w_shamt;
            OP_SRL:  w_alu = w_fwd_b >> w_shamt;
            default: w_alu = '0;
        endcase
    end

    ex_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst),
        .i_start  (w_accept),
        .i_op     (alu_op),
        .i_a      (w_fwd_a),
        .i_b      (w_b),
        .i_flush  (flush),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // Stall covers the accept cycle plus every BUSY cycle except the last
    assign stall = rst && ~flush && (w_accept || ((r_state == ST_BUSY) && ~w_md_done));

    // FSM: accept multi-cycle op, hold its metadata, return to IDLE on done/flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_hold_dest  <= '0;
            r_hold_store <= '0;
            r_hold_mr    <= 1'b0;
            r_hold_mw    <= 1'b0;
            r_hold_rw    <= 1'b0;
            r_hold_m2r   <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_BUSY;
                        r_hold_dest  <= w_dest;
                        r_hold_store <= w_fwd_b;
                        r_hold_mr    <= mem_read;
                        r_hold_mw    <= mem_write;
                        r_hold_rw    <= reg_write;
                        r_hold_m2r   <= mem_to_reg;
                    end
                end
                ST_BUSY: begin
                    if (w_md_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // EX/MEM register: bubble (all zeros) unless a result is ready this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_res        <= '0;
            out_store      <= '0;
            out_dest       <= '0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            out_res        <= '0;
            out_store      <= '0;
            out_dest       <= '0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            if (!flush) begin
                if (r_state == ST_BUSY) begin
                    if (w_md_done) begin
                        out_valid      <= 1'b1;
                        out_res        <= w_md_result;
                        out_store      <= r_hold_store;
                        out_dest       <= r_hold_dest;
                        out_mem_read   <= r_hold_mr;
                        out_mem_write  <= r_hold_mw;
                        out_reg_write  <= r_hold_rw;
                        out_mem_to_reg <= r_hold_m2r;
                    end
                end else if (in_valid && !w_is_multi) begin
                    out_valid      <= 1'b1;
                    out_res        <= w_alu;
                    out_store      <= w_fwd_b;
                    out_dest       <= w_dest;
                    out_mem_read   <= mem_read;
                    out_mem_write  <= mem_write;
                    out_reg_write  <= reg_write;
                    out_mem_to_reg <= mem_to_reg;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ex_stage_mc
// Purpose  : Directed self-checking bench for ex_stage_mc. A WIDTH=32 and a
//            WIDTH=8 instance share one stimulus set (the 8-bit one sees the
//            low byte of each data input).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ex_stage_mc;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, flush, alu_src, reg_dst;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic [3:0]  alu_op;
    logic [4:0]  rs, rt, rd, mem_dest, wb_dest;
    logic [31:0] rs_data, rt_data, imm, mem_fwd_data, wb_fwd_data;
    logic        mem_reg_write, wb_reg_write;

    logic        s32, v32, mr32, mw32, rw32, m2r32;
    logic [31:0] res32, st32;
    logic [4:0]  d32;
    logic        s8, v8, mr8, mw8, rw8, m2r8;
    logic [7:0]  res8, st8;
    logic [4:0]  d8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_stage_mc #(.WIDTH(32), .REG_ADDR_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .rs(rs), .rt(rt), .rd(rd),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_fwd_data(mem_fwd_data),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_fwd_data(wb_fwd_data),
        .stall(s32), .out_valid(v32), .out_res(res32), .out_store(st32),
        .out_dest(d32), .out_mem_read(mr32), .out_mem_write(mw32),
        .out_reg_write(rw32), .out_mem_to_reg(m2r32)
    );

    ex_stage_mc #(.WIDTH(8), .REG_ADDR_W(5)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .rs(rs), .rt(rt), .rd(rd),
        .rs_data(rs_data[7:0]), .rt_data(rt_data[7:0]), .imm(imm[7:0]),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_fwd_data(mem_fwd_data[7:0]),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_fwd_data(wb_fwd_data[7:0]),
        .stall(s8), .out_valid(v8), .out_res(res8), .out_store(st8),
        .out_dest(d8), .out_mem_read(mr8), .out_mem_write(mw8),
        .out_reg_write(rw8), .out_mem_to_reg(m2r8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain instruction on rs=1/rt=2 with forwarding disabled
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid      = 1'b1;
        alu_op        = op;
        rs            = 5'd1;
        rt            = 5'd2;
        rd            = 5'd9;
        reg_dst       = 1'b1;
        alu_src       = 1'b0;
        rs_data       = a;
        rt_data       = b;
        mem_reg_write = 1'b0;
        wb_reg_write  = 1'b0;
    endtask

    // Multi-cycle op on the 8-bit instance; returns result and edge count to out_valid
    task automatic run_mc8(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [7:0] res, output int lat);
        in_valid = 1'b0;
        tick();
        issue(op, a, b);
        tick();
        lat = 1;
        while (!v8 && lat < 20) begin
            tick();
            lat++;
        end
        res      = res8;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        int         lat;
        int         nst;
        int         nv;

        in_valid = 0; flush = 0; alu_op = 0; alu_src = 0; reg_dst = 0;
        mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
        rs = 0; rt = 0; rd = 0; rs_data = 0; rt_data = 0; imm = 0;
        mem_reg_write = 0; mem_dest = 0; mem_fwd_data = 0;
        wb_reg_write = 0; wb_dest = 0; wb_fwd_data = 0;

        // Reset state
        repeat (2) tick();
        check("rst_valid32", 32'(v32), 32'd0);
        check("rst_res32",   res32,    32'd0);
        check("rst_stall32", 32'(s32), 32'd0);
        check("rst_ctrl32",  32'({mr32, mw32, rw32, m2r32, d32}), 32'd0);
        check("rst_valid8",  32'(v8),  32'd0);
        rst = 1'b1;
        tick();

        // MEM has priority over WB on A
        in_valid = 1; alu_op = OP_ADD; rs = 3; rt = 4; rd = 7; reg_dst = 1; alu_src = 0;
        mem_reg_write = 1; mem_dest = 3; mem_fwd_data = 32'h10;
        wb_reg_write  = 1; wb_dest  = 3; wb_fwd_data  = 32'h20;
        rs_data = 32'h99; rt_data = 5; reg_write = 1; mem_write = 1;
        tick();
        check("fwd_mem_res",   res32,    32'h15);
        check("fwd_mem_valid", 32'(v32), 32'd1);
        check("fwd_mem_dest",  32'(d32), 32'd7);
        check("fwd_mem_ctrl",  32'({mr32, mw32, rw32, m2r32}), 32'b0110);
        check("fwd_mem_store", st32,     32'd5);

        // A from MEM, B (rt=6) from WB
        rt = 6; wb_dest = 6; mem_write = 0;
        tick();
        check("fwd_wb_res",   res32, 32'h30);
        check("fwd_wb_store", st32,  32'h20);

        // r0 is never forwarded; immediate as B, dest = rt
        rs = 0; rt = 4; mem_dest = 0; mem_fwd_data = 32'hFF; wb_reg_write = 0;
        rs_data = 7; imm = 1; alu_src = 1; reg_dst = 0;
        tick();
        check("r0_res",   res32,    32'd8);
        check("r0_store", st32,     32'd5);
        check("r0_dest",  32'(d32), 32'd4);

        // Shifts, unused opcode, bubble, flush of a single-cycle op
        issue(OP_SLL, 0, 3); imm = 4;
        tick();
        check("sll", res32, 32'h30);
        issue(OP_SRL, 0, 32'h8000_0000); imm = 31;
        tick();
        check("srl", res32, 32'd1);
        issue(4'd13, 5, 6);
        tick();
        check("op13_res",   res32,    32'd0);
        check("op13_valid", 32'(v32), 32'd1);
        in_valid = 0;
        tick();
        check("idle_valid", 32'(v32), 32'd0);
        check("idle_res",   res32,    32'd0);
        issue(OP_ADD, 1, 1); flush = 1;
        tick();
        check("flush_alu_valid", 32'(v32), 32'd0);
        flush = 0; in_valid = 0;

        // MUL 13*11 on WIDTH=8: stall 8 cycles, result on edge 9
        rst = 0; #2; rst = 1;
        tick();
        issue(OP_MUL, 13, 11);
        #1;
        nst = 0; nv = 0;
        for (int i = 0; i < 9; i++) begin
            if (s8) nst++;
            if (v8) nv++;
            tick();
        end
        check("mul_stall_cycles", 32'(nst), 32'd8);
        check("mul_early_valid",  32'(nv),  32'd0);
        check("mul_valid",        32'(v8),  32'd1);
        check("mul_res",          32'(res8), 32'h8F);
        check("mul_dest",         32'(d8),  32'd9);
        in_valid = 0;

        // Division cases, including divide by zero
        run_mc8(OP_DIVU, 200, 7, r, lat);
        check("divu_res", 32'(r), 32'd28);
        check("divu_lat", 32'(lat), 32'd9);
        run_mc8(OP_REMU, 200, 7, r, lat);
        check("remu_res", 32'(r), 32'd4);
        run_mc8(OP_DIVU, 9, 0, r, lat);
        check("divu0_res", 32'(r), 32'hFF);
        run_mc8(OP_REMU, 9, 0, r, lat);
        check("remu0_res", 32'(r), 32'd9);

        // Flush on the 4th BUSY cycle, then ADD 1+2
        tick();
        issue(OP_MUL, 13, 11);
        repeat (4) tick();
        check("pre_flush_stall", 32'(s8), 32'd1);
        flush = 1;
        #1;
        check("flush_stall", 32'(s8), 32'd0);
        tick();
        flush = 0;
        check("flush_bubble", 32'(v8), 32'd0);
        issue(OP_ADD, 1, 2);
        #1;
        check("post_flush_nostall", 32'(s8), 32'd0);
        tick();
        check("post_flush_valid", 32'(v8), 32'd1);
        check("post_flush_res",   32'(res8), 32'd3);
        in_valid = 0;
        nv = 0;
        repeat (12) begin
            tick();
            if (v8) nv++;
        end
        check("flushed_mul_silent", 32'(nv), 32'd0);

        // Reset mid-BUSY on WIDTH=32
        rst = 0; #2; rst = 1;
        tick();
        issue(OP_MUL, 3, 4);
        repeat (5) tick();
        check("busy_stall32", 32'(s32), 32'd1);
        check("busy_valid32", 32'(v32), 32'd0);
        rst = 0;
        #1;
        check("rst_busy_stall32", 32'(s32), 32'd0);
        check("rst_busy_valid32", 32'(v32), 32'd0);
        check("rst_busy_res32",   res32,    32'd0);
        check("rst_busy_stall8",  32'(s8),  32'd0);
        in_valid = 0;
        #2;
        rst = 1;
        tick();

        // Post-reset single-cycle ops
        issue(OP_SUB, 5, 9);
        tick();
        check("sub_res",   res32,    32'hFFFF_FFFC);
        check("sub_valid", 32'(v32), 32'd1);
        issue(OP_SLT, 5, 9);
        tick();
        check("slt_pos", res32, 32'd1);
        issue(OP_SLT, 32'hFFFF_FFFD, 2);
        tick();
        check("slt_neg", res32, 32'd1);
        issue(OP_SLTU, 32'hFFFF_FFFD, 2);
        tick();
        check("sltu_neg", res32, 32'd0);
        in_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised execute stage for the MIPS pipeline.
- Contains operand forwarding from MEM and WB, a single-cycle ALU, and an iterative multi-cycle MUL/DIVU unit.
- Registers its results into the EX/MEM pipeline register.
- Asserts a stall to upstream stages while a multi-cycle op is in flight. Sits between the ID/EX register and the MEM stage.

Parameters:
- WIDTH, 32: datapath width in bits (≥4).
- REG_ADDR_W, 5: register-file address width.
- CNT_W, $clog2(WIDTH): iteration counter width (derived; not overridden).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID/EX holds a valid instruction.
- flush  in  1  kill the current EX instruction and any in-flight multi-cycle op.
- alu_op  in  4  operation: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, MUL=10, DIVU=11, REMU=12. Other codes yield 0.
- alu_src  in  1  1: B operand is imm, 0: forwarded rt data.
- reg_dst  in  1  1: dest=rd, 0: dest=rt.
- mem_read, mem_write, reg_write, mem_to_reg  in  1 each  control bits passed through.
- rs, rt, rd  in  REG_ADDR_W  source/destination register numbers.
- rs_data, rt_data, imm  in  WIDTH  register-file read data and sign-extended immediate.
- mem_reg_write  in  1  regWrite of the instruction in MEM.
- mem_dest  in  REG_ADDR_W  destination register of the instruction in MEM.
- mem_fwd_data  in  WIDTH  forwardable result from MEM.
- wb_reg_write  in  1  regWrite of the instruction in WB.
- wb_dest  in  REG_ADDR_W  destination register of the instruction in WB.
- wb_fwd_data  in  WIDTH  forwardable result from WB.
- stall  out  1  upstream must hold PC, IF/ID and ID/EX.
- out_valid  out  1  EX/MEM register holds a valid instruction.
- out_res  out  WIDTH  ALU, MUL or DIV result.
- out_store  out  WIDTH  forwarded rt data, for stores.
- out_dest  out  REG_ADDR_W  destination register.
- out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  out  1 each  registered control bits.

Behaviour:
- Reset (rst=0, async): all outputs and internal registers go to 0; FSM=IDLE; stall=0.
- Forwarding (combinational), for each of A (rs) and B (rt):
  - If mem_reg_write and mem_dest!=0 and mem_dest==src, take mem_fwd_data.
  - Else if wb_reg_write and wb_dest!=0 and wb_dest==src, take wb_fwd_data.
  - Else take the register-file data.
  - MEM has priority over WB.
- Operand B and store data: B = alu_src ? imm : fwd_rt. out_store always carries fwd_rt.
- Shifts: shift amount = imm[CNT_W-1:0]; the shifted value is fwd_rt.
- SLT compares signed; SLTU compares unsigned.
- Single-cycle ops: result is registered on the next rising edge, latency 1. The bubble rule is out_valid <= in_valid & ~flush.
- FSM states:
  - IDLE: if in_valid & MUL/DIVU/REMU & ~flush, capture A, B, op, dest and control bits; counter=0; stall=1; go BUSY. During this accept edge, the EX/MEM register loads a bubble (out_valid<=0).
  - BUSY: one iteration per cycle. MUL is shift-add producing the low WIDTH bits. DIVU/REMU is restoring division. counter increments each cycle.
    - stall=1 while counter<WIDTH-1.
    - When counter==WIDTH-1, stall=0. On that edge, the final result and the captured control bits load into EX/MEM with out_valid=1, and the FSM goes to IDLE.
- Multi-cycle timing:
  - Total latency is WIDTH+1 edges from acceptance to out_valid.
  - stall is high for exactly WIDTH cycles.
  - The held instruction is never re-accepted, because upstream advances on the same edge the result is written.
- Operands are frozen at acceptance; forwarding-input changes during BUSY are ignored.
- Divide by zero: DIVU result is all ones; REMU result is the dividend.
- flush:
  - In any state, flush forces the FSM to IDLE with stall=0 that cycle.
  - EX/MEM loads a bubble.
  - Partial results are discarded.
  - flush has priority over acceptance and completion.
- in_valid=0 while IDLE: EX/MEM loads a bubble. Data fields may hold don't-care values but are deterministic: all register bits load 0 when in_valid=0.
- reset during BUSY: immediate return to IDLE; all outputs 0.

Decomposition:
- Package ex_pkg holds:
  - the alu_op enum and its encodings;
  - the FSM state typedef (IDLE, BUSY);
  - the forward-select constants (FWD_RF, FWD_MEM, FWD_WB).
- One sub-module, ex_muldiv_iter: the iterative multiplier/divider with start, op, a, b, flush, done and result. The forwarding mux and the single-cycle ALU stay inline.

Test Plan:
- WIDTH=32, rs=3, mem_dest=3, mem_reg_write=1, mem_fwd_data=0x10, wb_dest=3, wb_fwd_data=0x20, rt_data=5, ADD, alu_src=0 -> out_res=0x15 next edge. This checks MEM priority.
- rs=0, mem_dest=0, mem_reg_write=1, mem_fwd_data=0xFF, rs_data=7, imm=1, alu_src=1, ADD -> out_res=8. This checks that r0 is never forwarded.
- WIDTH=8, MUL A=13, B=11 -> stall high for 8 cycles, out_valid=1 with out_res=0x8F (143) on edge 9, with out_valid=0 before it.
- WIDTH=8, DIVU 200/7 -> out_res=28. REMU 200/7 -> out_res=4. DIVU 9/0 -> out_res=0xFF.
- WIDTH=8, start MUL, assert flush on the 4th BUSY cycle -> stall=0 that cycle, no out_valid for that MUL, and the next ADD 1+2 completes as out_res=3 one edge after acceptance.
- Assert rst low mid-BUSY -> all outputs 0 immediately. After release, SUB 5-9 -> out_res=0xFFFFFFFC (WIDTH=32) and SLT gives 1.
